// File: rtl/stage_strobe_gen.sv
// rtl/stage_strobe_gen.sv - stage bus consumer: one-hot stage enables, sequence check, cycle/instret counters
module stage_strobe_gen #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            stage_in,
    input  logic                  halt,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  instr_done,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret_cnt,
    output logic                  synced,
    output logic                  seq_error
);

    typedef enum logic {SYNC, TRACK} state_e;

    localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);

    state_e                state_q, state_d;
    logic [2:0]            expected_q, expected_d;
    logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
    logic                  instr_done_q, instr_done_d;
    logic [CNT_W-1:0]      cycle_q, cycle_d;
    logic [CNT_W-1:0]      instret_q, instret_d;
    logic                  seq_error_q, seq_error_d;
    logic                  legal;

    // The range check guards the decode even though expected_q never leaves 0..LAST.
    assign legal = (stage_in == expected_q) && (stage_in <= LAST);

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        stage_en_d   = '0;
        instr_done_d = 1'b0;
        seq_error_d  = seq_error_q;
        cycle_d      = halt ? cycle_q : cycle_q + CNT_W'(1);
        instret_d    = instret_q;

        case (state_q)
            SYNC: begin
                expected_d = 3'd0;
                if (stage_in == 3'd0) begin
                    state_d    = TRACK;
                    stage_en_d = NUM_STAGES'(1);
                    expected_d = 3'd1;
                end
            end
            TRACK: begin
                if (legal) begin
                    stage_en_d = NUM_STAGES'(1) << stage_in;
                    if (stage_in == LAST) begin
                        expected_d   = 3'd0;
                        instr_done_d = 1'b1;
                        if (!halt) begin
                            instret_d = instret_q + CNT_W'(1);
                        end
                    end else begin
                        expected_d = stage_in + 3'd1;
                    end
                end else begin
                    state_d     = SYNC;
                    expected_d  = 3'd0;
                    seq_error_d = 1'b1;
                end
            end
            default: begin
                state_d    = SYNC;
                expected_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SYNC;
            expected_q   <= 3'd0;
            stage_en_q   <= '0;
            instr_done_q <= 1'b0;
            cycle_q      <= '0;
            instret_q    <= '0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            stage_en_q   <= stage_en_d;
            instr_done_q <= instr_done_d;
            cycle_q      <= cycle_d;
            instret_q    <= instret_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign stage_en    = stage_en_q;
    assign instr_done  = instr_done_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
    assign synced      = (state_q == TRACK);
    assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_stage_strobe_gen.sv
// tb/tb_stage_strobe_gen.sv - directed bench for stage_strobe_gen (5 stages; 64-bit and 8-bit counter builds)
module tb_stage_strobe_gen;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [2:0]  stage_in = 3'd0;
    logic        halt = 1'b0;

    logic [4:0]  stage_en_a, stage_en_b;
    logic        instr_done_a, instr_done_b;
    logic [63:0] cycle_a, instret_a;
    logic [7:0]  cycle_b, instret_b;
    logic        synced_a, synced_b;
    logic        seq_error_a, seq_error_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stage_strobe_gen #(.NUM_STAGES(5), .CNT_W(64)) dut_a (
        .clk(clk), .rst(rst_a), .stage_in(stage_in), .halt(halt),
        .stage_en(stage_en_a), .instr_done(instr_done_a), .cycle_cnt(cycle_a),
        .instret_cnt(instret_a), .synced(synced_a), .seq_error(seq_error_a)
    );

    stage_strobe_gen #(.NUM_STAGES(5), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .stage_in(stage_in), .halt(halt),
        .stage_en(stage_en_b), .instr_done(instr_done_b), .cycle_cnt(cycle_b),
        .instret_cnt(instret_b), .synced(synced_b), .seq_error(seq_error_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [2:0] s, input logic h);
        stage_in = s;
        halt     = h;
        tick();
    endtask

    // Pulse dut_a reset between edges and confirm the clear does not wait for a clock.
    task automatic reset_a_midcycle(input string tag);
        #2 rst_a = 1'b0;
        #1;
        chk({tag, "_async_en"}, 64'(stage_en_a), 64'd0);
        chk({tag, "_async_cyc"}, cycle_a, 64'd0);
        chk({tag, "_async_sync"}, 64'(synced_a), 64'd0);
        chk({tag, "_async_err"}, 64'(seq_error_a), 64'd0);
        #1 rst_a = 1'b1;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_en", 64'(stage_en_a), 64'd0);
        chk("rst_done", 64'(instr_done_a), 64'd0);
        chk("rst_cyc", cycle_a, 64'd0);
        chk("rst_ret", instret_a, 64'd0);
        chk("rst_sync", 64'(synced_a), 64'd0);
        chk("rst_err", 64'(seq_error_a), 64'd0);
        rst_a = 1'b1;

        // four clean instructions: 0,1,2,3,4 repeated
        for (int k = 0; k < 20; k++) begin
            feed(3'(k % 5), 1'b0);
            chk("cyc_en", 64'(stage_en_a), 64'(5'b00001 << (k % 5)));
            chk("cyc_done", 64'(instr_done_a), 64'((k % 5) == 4));
        end
        chk("cyc20_ret", instret_a, 64'd4);
        chk("cyc20_cyc", cycle_a, 64'd20);

        // mid-instruction reset while stage 2 is enabled
        feed(3'd0, 1'b0);
        feed(3'd1, 1'b0);
        feed(3'd2, 1'b0);
        chk("mid_en2", 64'(stage_en_a), 64'h4);
        reset_a_midcycle("mid");

        // hold a non-zero stage in SYNC
        for (int k = 0; k < 4; k++) begin
            feed(3'd3, 1'b0);
            chk("hold_sync", 64'(synced_a), 64'd0);
            chk("hold_en", 64'(stage_en_a), 64'd0);
            chk("hold_err", 64'(seq_error_a), 64'd0);
        end
        feed(3'd0, 1'b0);
        chk("lock_sync", 64'(synced_a), 64'd1);
        chk("lock_en0", 64'(stage_en_a), 64'h1);
        feed(3'd1, 1'b0);
        chk("lock_en1", 64'(stage_en_a), 64'h2);

        // skip 1 -> 3
        feed(3'd3, 1'b0);
        chk("skip_err", 64'(seq_error_a), 64'd1);
        chk("skip_sync", 64'(synced_a), 64'd0);
        chk("skip_en", 64'(stage_en_a), 64'd0);
        for (int k = 0; k < 3; k++) begin
            feed(3'(k), 1'b0);
            chk("resync_en", 64'(stage_en_a), 64'(5'b00001 << k));
            chk("resync_err", 64'(seq_error_a), 64'd1);
            chk("resync_sync", 64'(synced_a), 64'd1);
        end

        // out-of-range stage index
        reset_a_midcycle("oor");
        feed(3'd0, 1'b0);
        feed(3'd1, 1'b0);
        chk("oor_pre_err", 64'(seq_error_a), 64'd0);
        feed(3'd6, 1'b0);
        chk("oor_err", 64'(seq_error_a), 64'd1);
        chk("oor_sync", 64'(synced_a), 64'd0);
        chk("oor_en", 64'(stage_en_a), 64'd0);

        // halt behaviour
        reset_a_midcycle("halt");
        for (int k = 0; k < 5; k++) feed(3'(k), 1'b0);
        chk("h_a_cyc", cycle_a, 64'd5);
        chk("h_a_ret", instret_a, 64'd1);
        for (int k = 0; k < 5; k++) begin
            feed(3'(k), 1'b1);
            chk("h_b_cyc", cycle_a, 64'd5);
            chk("h_b_ret", instret_a, 64'd1);
        end
        chk("h_b_done", 64'(instr_done_a), 64'd1);
        for (int k = 0; k < 4; k++) feed(3'(k), 1'b1);
        feed(3'd4, 1'b0);
        chk("h_c_cyc", cycle_a, 64'd6);
        chk("h_c_ret", instret_a, 64'd2);
        for (int k = 0; k < 5; k++) feed(3'(k), 1'b0);
        chk("h_d_cyc", cycle_a, 64'd11);
        chk("h_d_ret", instret_a, 64'd3);

        // 8-bit counter wrap on dut_b
        chk("b_rst_cyc", 64'(cycle_b), 64'd0);
        chk("b_rst_ret", 64'(instret_b), 64'd0);
        rst_b = 1'b1;
        for (int i = 0; i < 255; i++) begin
            for (int k = 0; k < 5; k++) feed(3'(k), 1'b0);
        end
        chk("b_ret255", 64'(instret_b), 64'd255);
        chk("b_cyc251", 64'(cycle_b), 64'd251);
        for (int k = 0; k < 4; k++) feed(3'(k), 1'b0);
        chk("b_cyc255", 64'(cycle_b), 64'd255);
        feed(3'd4, 1'b0);
        chk("b_cyc_wrap", 64'(cycle_b), 64'd0);
        chk("b_ret_wrap", 64'(instret_b), 64'd0);
        chk("b_done", 64'(instr_done_b), 64'd1);
        chk("b_err", 64'(seq_error_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
